// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a counted, checksummed frame of 32-bit words
// into instruction memory and holds the SISC core in reset until a frame checks out.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_f,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         asm_q, asm_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;

  logic                accept;
  logic [15:0]         count_in;
  logic [31:0]         next_word;
  logic                load_state;

  assign accept    = rx_valid && rx_ready_q;
  assign count_in  = {cnt_q[15:8], rx_data};
  assign next_word = {asm_q[23:0], rx_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    bidx_d  = bidx_q;
    csum_d  = csum_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    case (state_q)
      S_CNT_HI: begin
        if (accept) begin
          cnt_d   = {rx_data, 8'h00};
          csum_d  = 8'h00;
          bidx_d  = 2'd0;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d = count_in;
          if (count_in == 16'd0) begin
            state_d = S_CSUM;
          end else if (32'(count_in) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d  = next_word;
          csum_d = csum_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          // The word address is the count of words already written, so it
          // stays in range even when the frame fills memory exactly.
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = next_word;
            waddr_d = words_q[ADDR_W-1:0];
            words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
            if ((32'(words_q) + 32'd1) == 32'(cnt_q)) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (load_req) begin
          state_d = S_CNT_HI;
          cnt_d   = 16'd0;
          bidx_d  = 2'd0;
          csum_d  = 8'h00;
          words_d = '0;
          waddr_d = '0;
        end
      end
      default: begin
        state_d = S_CNT_HI;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change together
  // with the state itself.
  always_comb begin
    load_state = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
    rx_ready_d = load_state;
    busy_d     = load_state;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rst_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= S_CNT_HI;
      cnt_q      <= 16'd0;
      asm_q      <= 32'd0;
      bidx_q     <= 2'd0;
      csum_q     <= 8'h00;
      words_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      bidx_q     <= bidx_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = we_q;
  assign im_waddr     = waddr_q;
  assign im_wdata     = wdata_q;
  assign cpu_rst_f    = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader: expected memory writes go into a
// scoreboard queue and a monitor checks every write strobe against it.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_f;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              load_req;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_rst_f;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          total;
  int          bad;
  logic [31:0] fix_w[0:3];
  bit          use_fix;
  int          last_words;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_f        (rst_f),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .load_req     (load_req),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .cpu_rst_f    (cpu_rst_f),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp_v);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(posedge clk) begin
    #1;
    if (rst_f === 1'b1 && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", im_waddr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("im_waddr", 32'(im_waddr), mon_e.addr);
        checkOutput("im_wdata", im_wdata, mon_e.data);
        checkOutput("words_at_write", 32'(words_loaded), mon_e.addr + 1);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int w;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if ($urandom_range(0, 15) == 0) load_req = 1'b1;
    w = 0;
    while (rx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout actual=rx_ready low required=high");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  function automatic int pickGap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic checkStatus(input bit e_done, input bit e_err, input int e_words);
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("err", 32'(err), 32'(e_err));
    checkOutput("cpu_rst_f", 32'(cpu_rst_f), 32'(e_done));
    checkOutput("busy", 32'(busy), 32'(!(e_done || e_err)));
    checkOutput("rx_ready", 32'(rx_ready), 32'(!(e_done || e_err)));
    checkOutput("words_loaded", 32'(words_loaded), e_words);
  endtask

  // Frame-level reference: N words, XOR checksum of data bytes, optional bad checksum.
  task automatic applyStimulus(input int n, input bit bad_cs, input int gap_mode);
    logic [15:0] n16;
    logic [31:0] w;
    logic [7:0]  cs;
    wr_t         e;
    n16 = 16'(n);
    cs  = 8'h00;
    sendByte(n16[15:8], pickGap(gap_mode));
    sendByte(n16[7:0], pickGap(gap_mode));
    if (n > (1 << ADDR_W)) begin
      @(negedge clk);
      checkStatus(1'b0, 1'b1, 0);
      last_words = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = use_fix ? fix_w[i] : $urandom;
        e.addr = i;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 3; k >= 0; k--) begin
          cs = cs ^ w[k*8 +: 8];
          sendByte(w[k*8 +: 8], pickGap(gap_mode));
        end
      end
      sendByte(bad_cs ? (cs ^ 8'h01) : cs, pickGap(gap_mode));
      @(negedge clk);
      checkStatus(!bad_cs, bad_cs, n);
      last_words = n;
    end
  endtask

  // Idle bytes offered in DONE/ERR must be ignored, then load_req restarts.
  task automatic reloadFrame();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("words_held_idle", 32'(words_loaded), last_words);
    checkOutput("ready_low_idle", 32'(rx_ready), 32'd0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checkStatus(1'b0, 1'b0, 0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    use_fix    = 1'b0;
    last_words = 0;
    rst_f      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    load_req   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_im_we", 32'(im_we), 32'd0);
    checkOutput("rst_im_waddr", 32'(im_waddr), 32'd0);
    checkOutput("rst_im_wdata", im_wdata, 32'd0);
    checkStatus(1'b0, 1'b0, 0);
    rst_f = 1'b1;

    $display("[TB] single word frame");
    use_fix  = 1'b1;
    fix_w[0] = 32'h12345678;
    applyStimulus(1, 1'b0, 0);

    $display("[TB] three words, alternate-cycle valid");
    reloadFrame();
    fix_w[0] = 32'hA0000001;
    fix_w[1] = 32'hB0000002;
    fix_w[2] = 32'hC0000003;
    applyStimulus(3, 1'b0, 1);

    $display("[TB] checksum mismatch");
    reloadFrame();
    fix_w[0] = 32'h12345678;
    applyStimulus(1, 1'b1, 0);

    $display("[TB] oversize count");
    reloadFrame();
    applyStimulus(257, 1'b0, 0);

    $display("[TB] empty frame");
    reloadFrame();
    applyStimulus(0, 1'b0, 0);

    $display("[TB] reset in the middle of a word");
    reloadFrame();
    fix_w[0] = 32'hA0000001;
    fix_w[1] = 32'hB0000002;
    fix_w[2] = 32'hC0000003;
    applyStimulus(3, 1'b0, 2);
    reloadFrame();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'h55, 0);
    sendByte(8'h66, 0);
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    checkOutput("midrst_im_we", 32'(im_we), 32'd0);
    checkOutput("midrst_im_waddr", 32'(im_waddr), 32'd0);
    checkOutput("midrst_im_wdata", im_wdata, 32'd0);
    checkStatus(1'b0, 1'b0, 0);
    @(negedge clk);
    rst_f = 1'b1;
    fix_w[0] = 32'hDEADBEEF;
    applyStimulus(1, 1'b0, 0);

    $display("[TB] full memory frame");
    use_fix = 1'b0;
    reloadFrame();
    applyStimulus(1 << ADDR_W, 1'b0, 0);

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      reloadFrame();
      if ($urandom_range(0, 5) == 0) begin
        applyStimulus($urandom_range(257, 65535), 1'b0, 2);
      end else begin
        applyStimulus($urandom_range(0, 8), ($urandom_range(0, 3) == 0), 2);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
